// File: rtl/ov7670_capture_if.sv
// ---------------------------------------------------------------------------
// ov7670_capture_if
//
// Frame-buffer write port that the OV7670 capture block drives.
//
//   frame_addr   [ADDR_W-1:0]  linear pixel write address
//   frame_pixel  [11:0]        write data {R[3:0], G[3:0], B[3:0]}
//   frame_we                   write enable, one cycle per pixel
//   frame_done                 one-cycle pulse at the end of a frame that
//                              wrote at least one pixel
//
// Modports:
//   master - the capture block (drives every signal)
//   slave  - the frame buffer / observer (samples every signal)
//
// ADDR_W must match the ADDR_W of the ov7670_capture instance it connects to.
// ---------------------------------------------------------------------------
interface ov7670_capture_if #(
    parameter int ADDR_W = 19
);
    logic [ADDR_W-1:0] frame_addr;
    logic [11:0]       frame_pixel;
    logic              frame_we;
    logic              frame_done;

    modport master (
        output frame_addr,
        output frame_pixel,
        output frame_we,
        output frame_done
    );

    modport slave (
        input frame_addr,
        input frame_pixel,
        input frame_we,
        input frame_done
    );
endinterface

// File: rtl/ov7670_capture.sv
// ---------------------------------------------------------------------------
// ov7670_capture
//
// Captures RGB444 pixels from the OV7670 parallel bus and writes them into
// the frame buffer (the writer side of the buffer the VGA scan-out reads).
// Everything runs on the rising edge of the camera pixel clock.
//
// Two bytes form one 12-bit pixel: the low nibble of the first byte is R,
// the second byte is {G, B}. Pixels are written to a linear address that
// restarts at 0 every frame; writes at or beyond MAX_PIXELS are dropped.
//
// Parameters:
//   MAX_PIXELS  frame buffer depth in pixels (default 640x480)
//   ADDR_W      width of frame_addr
//
// Ports:
//   pclk       camera pixel clock
//   reset_n    asynchronous active-low reset
//   cam_vsync  camera vertical sync (high = between frames)
//   cam_href   camera line valid (high = cam_data valid)
//   cam_data   camera byte bus
//   fb         frame-buffer write port (ov7670_capture_if.master):
//              frame_addr, frame_pixel, frame_we, frame_done
//
// Build option:
//   CAPTURE_HALF_RATE_EN  when defined, only every second frame is written
//                         (the first frame after reset is skipped). Skipped
//                         frames are still parsed, so phase and counter
//                         behave identically; only frame_we / frame_done
//                         are held low.
// ---------------------------------------------------------------------------
module ov7670_capture #(
    parameter int MAX_PIXELS = 307200,
    parameter int ADDR_W     = 19
) (
    input  logic                pclk,
    input  logic                reset_n,
    input  logic                cam_vsync,
    input  logic                cam_href,
    input  logic [7:0]          cam_data,
    ov7670_capture_if.master    fb
);

    // One extra bit so the counter can hold MAX_PIXELS even when it equals
    // 2**ADDR_W.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PIXELS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t           state;

    // Registered camera inputs; every control decision uses these copies.
    logic             vs_q;
    logic             hr_q;
    logic [7:0]       d_q;

    logic             phase;      // 0: expecting R byte, 1: expecting GB byte
    logic [3:0]       red_q;      // R nibble held between the two bytes
    logic [CNT_W-1:0] pix_cnt;    // pixels issued in the current frame

    // Gate for frame_we / frame_done. Constant 1 in the default build.
    logic             wr_allow;

`ifdef CAPTURE_HALF_RATE_EN
    // Set for the frames that must not be written; it flips on every
    // SYNC->ACTIVE transition, so the first frame after reset is skipped.
    logic             frame_skip;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            frame_skip <= 1'b0;
        end else if (state == SYNC && !vs_q) begin
            frame_skip <= ~frame_skip;
        end
    end

    assign wr_allow = ~frame_skip;
`else
    assign wr_allow = 1'b1;
`endif

    // -----------------------------------------------------------------------
    // Input stage
    // -----------------------------------------------------------------------
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            vs_q <= 1'b0;
            hr_q <= 1'b0;
            d_q  <= '0;
        end else begin
            vs_q <= cam_vsync;
            hr_q <= cam_href;
            d_q  <= cam_data;
        end
    end

    // -----------------------------------------------------------------------
    // Capture state machine with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            phase          <= 1'b0;
            red_q          <= '0;
            pix_cnt        <= '0;
            fb.frame_addr  <= '0;
            fb.frame_pixel <= '0;
            fb.frame_we    <= 1'b0;
            fb.frame_done  <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            fb.frame_we   <= 1'b0;
            fb.frame_done <= 1'b0;

            case (state)
                // Wait for a vsync high period so a frame already in progress
                // at reset release is never captured.
                IDLE: begin
                    phase   <= 1'b0;
                    pix_cnt <= '0;
                    if (vs_q) begin
                        state <= SYNC;
                    end
                end

                SYNC: begin
                    phase   <= 1'b0;
                    pix_cnt <= '0;
                    if (!vs_q) begin
                        state <= ACTIVE;
                    end
                end

                ACTIVE: begin
                    if (vs_q) begin
                        // vsync outranks href: drop any pending half-pixel.
                        state         <= SYNC;
                        phase         <= 1'b0;
                        fb.frame_done <= (pix_cnt != '0) && wr_allow;
                    end else if (hr_q) begin
                        if (!phase) begin
                            red_q <= d_q[3:0];
                            phase <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            // At the buffer limit the counter holds and the
                            // write is suppressed; it never wraps mid-frame.
                            if (pix_cnt != MAX_CNT) begin
                                pix_cnt <= pix_cnt + 1'b1;
                                if (wr_allow) begin
                                    fb.frame_we    <= 1'b1;
                                    fb.frame_addr  <= pix_cnt[ADDR_W-1:0];
                                    fb.frame_pixel <= {red_q, d_q};
                                end
                            end
                        end
                    end else begin
                        // Line gap: a trailing odd byte is discarded.
                        phase <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    phase <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_capture.sv
// ---------------------------------------------------------------------------
// tb_ov7670_capture
//
// Self-checking bench for ov7670_capture (instantiated with MAX_PIXELS = 4).
// Expected writes are pushed to a scoreboard as stimulus is driven; a monitor
// on the falling edge pops and compares them whenever frame_we is high.
// ---------------------------------------------------------------------------
module tb_ov7670_capture;

    localparam int ADDR_W = 19;

    logic       pclk;
    logic       reset_n;
    logic       cam_vsync;
    logic       cam_href;
    logic [7:0] cam_data;

    ov7670_capture_if #(.ADDR_W(ADDR_W)) fb_if ();

    ov7670_capture #(
        .MAX_PIXELS (4),
        .ADDR_W     (ADDR_W)
    ) u_dut (
        .pclk      (pclk),
        .reset_n   (reset_n),
        .cam_vsync (cam_vsync),
        .cam_href  (cam_href),
        .cam_data  (cam_data),
        .fb        (fb_if)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    int unsigned exp_addr_q[$];
    int unsigned exp_pix_q[$];
    int unsigned exp_done = 0;
    logic [7:0]  line_q[$];
    logic        prev_we = 1'b0;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Monitor: sample outputs away from the rising edge.
    always @(negedge pclk) begin
        check("we_spacing", int'(fb_if.frame_we & prev_we), 0);
        check("we_done_overlap", int'(fb_if.frame_we & fb_if.frame_done), 0);
        if (fb_if.frame_we) begin
            if (exp_addr_q.size() == 0) begin
                check("unexpected_we", 1, 0);
            end else begin
                check("frame_addr", int'(fb_if.frame_addr), exp_addr_q.pop_front());
                check("frame_pixel", int'(fb_if.frame_pixel), exp_pix_q.pop_front());
            end
        end
        if (fb_if.frame_done) begin
            if (exp_done == 0) check("unexpected_done", 1, 0);
            else exp_done--;
        end
        prev_we = fb_if.frame_we;
    end

    task automatic tick();
        @(posedge pclk);
        #2;
    endtask

    task automatic push_wr(input int unsigned addr, input int unsigned pix);
        exp_addr_q.push_back(addr);
        exp_pix_q.push_back(pix);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic vsync_pulse();
        cam_href  = 1'b0;
        cam_vsync = 1'b1;
        repeat (3) tick();
        cam_vsync = 1'b0;
        repeat (3) tick();
    endtask

    // Sends line_q as one href-high line, then a short blanking gap.
    task automatic send_line();
        cam_href = 1'b1;
        foreach (line_q[i]) begin
            cam_data = line_q[i];
            tick();
        end
        cam_href = 1'b0;
        cam_data = 8'h00;
        repeat (4) tick();
        line_q.delete();
    endtask

    task automatic end_test(input string name);
        repeat (4) tick();
        check({name, "_pending_we"}, exp_addr_q.size(), 0);
        check({name, "_pending_done"}, exp_done, 0);
        exp_addr_q.delete();
        exp_pix_q.delete();
        exp_done = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        cam_vsync = 1'b0;
        cam_href  = 1'b0;
        cam_data  = 8'h00;
        #1;
        check("rst_addr", int'(fb_if.frame_addr), 0);
        check("rst_pixel", int'(fb_if.frame_pixel), 0);
        check("rst_we", int'(fb_if.frame_we), 0);
        check("rst_done", int'(fb_if.frame_done), 0);
        tick();

`ifndef CAPTURE_HALF_RATE_EN
        // Minimal frame.
        do_reset();
        vsync_pulse();
        push_wr(0, 12'hABC);
        push_wr(1, 12'h567);
        line_q = '{8'h0A, 8'hBC, 8'h05, 8'h67};
        send_line();
        exp_done = 1;
        vsync_pulse();
        end_test("minimal");

        // Reset mid-line with a half pixel pending (outputs still 1 / 0x567).
        vsync_pulse();
        cam_href = 1'b1;
        cam_data = 8'h0E;
        repeat (2) tick();
        reset_n = 1'b0;
        #1;
        check("midrst_addr", int'(fb_if.frame_addr), 0);
        check("midrst_pixel", int'(fb_if.frame_pixel), 0);
        check("midrst_we", int'(fb_if.frame_we), 0);
        check("midrst_done", int'(fb_if.frame_done), 0);
        tick();
        cam_href = 1'b0;
        reset_n  = 1'b1;
        tick();
        // Reset released mid-frame: lines with vsync low must not be written.
        line_q = '{8'h01, 8'h11, 8'h02, 8'h22};
        send_line();
        line_q = '{8'h03, 8'h33};
        send_line();
        check("partial_no_we", exp_addr_q.size(), 0);
        vsync_pulse();
        push_wr(0, 12'h456);
        line_q = '{8'h04, 8'h56};
        send_line();
        exp_done = 1;
        vsync_pulse();
        end_test("partial");

        // Odd byte at line end is discarded.
        do_reset();
        vsync_pulse();
        push_wr(0, 12'hABC);
        line_q = '{8'h0A, 8'hBC, 8'h0F};
        send_line();
        push_wr(1, 12'h123);
        line_q = '{8'h01, 8'h23};
        send_line();
        exp_done = 1;
        vsync_pulse();
        end_test("odd");

        // Overflow: 6 pixels offered, buffer holds 4.
        do_reset();
        vsync_pulse();
        for (int i = 0; i < 6; i++) begin
            line_q.push_back(8'(8'hF0 | i));
            line_q.push_back(8'(8'h10 * i + 8'h07));
            if (i < 4) push_wr(i, (32'(i) << 8) | (32'h10 * i + 32'h07));
        end
        send_line();
        exp_done = 1;
        vsync_pulse();
        push_wr(0, 12'h9AB);
        line_q = '{8'h09, 8'hAB};
        send_line();
        exp_done = 1;
        vsync_pulse();
        end_test("overflow");

        // vsync rising mid-line drops the pending half pixel.
        do_reset();
        vsync_pulse();
        push_wr(0, 12'h1FF);
        cam_href = 1'b1;
        cam_data = 8'h01; tick();
        cam_data = 8'hFF; tick();
        cam_data = 8'h0D; tick();
        cam_vsync = 1'b1;
        cam_data  = 8'h99; tick();
        exp_done = 1;
        vsync_pulse();
        push_wr(0, 12'h234);
        line_q = '{8'h02, 8'h34};
        send_line();
        exp_done = 1;
        vsync_pulse();
        end_test("vs_midline");

        // Three 1-pixel frames, all written.
        do_reset();
        vsync_pulse();
        for (int f = 1; f <= 3; f++) begin
            push_wr(0, 32'(f) * 12'h111);
            line_q = '{8'(f), 8'(f * 8'h11)};
            send_line();
            exp_done = 1;
            vsync_pulse();
            end_test("three_frames");
        end
`else
        // Half rate: of three 1-pixel frames only the second is written.
        do_reset();
        vsync_pulse();
        for (int f = 1; f <= 3; f++) begin
            if (f == 2) begin
                push_wr(0, 12'h222);
                exp_done = 1;
            end
            line_q = '{8'(f), 8'(f * 8'h11)};
            send_line();
            vsync_pulse();
            end_test("half_rate");
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ov7670_capture.md
# ov7670_capture

Captures RGB444 pixel data from the OV7670 camera's parallel bus and writes it into the frame buffer. It is the writer side of the frame buffer that the VGA scan-out block reads. It runs entirely in the camera pixel-clock domain and sits between the camera pins and the frame buffer's write port. Each pair of bytes is assembled into one 12-bit pixel and written to a linear 19-bit address; the address restarts at 0 every frame.

## Interface

Parameters:
- MAX_PIXELS, 307200: frame buffer depth in pixels (640×480). Writes at or beyond this count are dropped.
- ADDR_W, 19: width of frame_addr.

Ports:
- pclk  input  1  camera pixel clock, the only clock; all logic is on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- cam_vsync  input  1  camera vertical sync; high = between frames.
- cam_href  input  1  camera line-valid; high = bytes on cam_data are valid.
- cam_data  input  8  camera byte bus.
- frame_addr  output  ADDR_W  write address into the frame buffer.
- frame_pixel  output  12  write data, {R[3:0], G[3:0], B[3:0]}.
- frame_we  output  1  write enable, one pclk per pixel.
- frame_done  output  1  one-cycle pulse at the end of a frame that wrote at least one pixel.

## Operation

- Input stage: cam_vsync, cam_href and cam_data are registered once (vs_q, hr_q, d_q). All control decisions use the registered copies.
- State machine: IDLE, SYNC, ACTIVE.
  - IDLE: entered on reset. Waits for vs_q = 1, then goes to SYNC. This prevents capturing a partial first frame.
  - SYNC: holds the pixel counter at 0 and the byte phase at 0. Goes to ACTIVE when vs_q = 0.
  - ACTIVE: captures bytes. Goes to SYNC when vs_q = 1; frame_done pulses on this transition if the pixel counter is nonzero.
- Byte assembly (ACTIVE only, hr_q = 1):
  - Phase 0: latch d_q[3:0] as R and set phase to 1.
  - Phase 1: form {R, d_q[7:0]}, issue the write, set phase to 0.
- hr_q = 0 forces phase to 0. A trailing odd byte at line end is discarded with no write.
- Address arithmetic:
  - frame_addr = pixel counter value at the time of the write.
  - The counter increments by 1 after each issued write.
  - When the counter equals MAX_PIXELS, the write is suppressed (frame_we stays 0) and the counter holds. It never wraps mid-frame.
- vsync during a line: vs_q = 1 has priority over hr_q. The state goes to SYNC, the phase clears, and any pending half-pixel is discarded.
- reset_n low at any time: immediate return to IDLE. All registers are cleared, including the input registers.

## Timing

- Reset values: frame_addr = 0, frame_pixel = 0, frame_we = 0, frame_done = 0, state = IDLE, phase = 0, counter = 0.
- Write latency: if the second byte of a pixel is on cam_data at pclk edge E, then frame_we, frame_addr and frame_pixel are valid after edge E+1 for exactly one cycle.
- frame_we is never high on two consecutive cycles; the minimum spacing is 2 pclk.
- frame_addr and frame_pixel hold their last written values while frame_we = 0.
- frame_done timing: if cam_vsync rises at edge E, frame_done is high for the cycle after edge E+1.
- frame_we and frame_done are never high in the same cycle.

## Configuration

- CAPTURE_HALF_RATE_EN:
  - Defined: a frame toggle flips on every SYNC→ACTIVE transition, and only frames with toggle = 1 issue writes and pulse frame_done. The first frame after reset is skipped. Odd frames are still parsed, so phase and counter behave identically, but frame_we and frame_done stay 0 for them.
  - Undefined: every frame is written.

## Test plan

- Reset mid-line: assert reset_n low while hr_q = 1 and phase = 1 -> all outputs are 0 the same cycle. After release, there are no writes until a full vsync high→low sequence.
- Minimal frame: vsync pulse, then one line of bytes 0x0A, 0xBC, 0x05, 0x67 -> frame_we pulses twice. The first has frame_addr = 0, frame_pixel = 0xABC; the second has frame_addr = 1, frame_pixel = 0x567. Rising vsync then gives one frame_done pulse.
- Odd byte at line end: line of 3 bytes, then a second line of 2 bytes 0x01, 0x23 -> exactly 2 writes, at addresses 0 and 1; the second carries 0x123.
- Overflow: MAX_PIXELS = 4, one line of 12 bytes -> 4 writes at addresses 0–3 and no fifth write. frame_done pulses at vsync. The next frame starts again at address 0.
- First partial frame: reset released while cam_vsync = 0 and lines are streaming -> no writes until after the first vsync high period.
- CAPTURE_HALF_RATE_EN defined, three 1-pixel frames -> only frame 2 writes (address 0) and pulses frame_done; frames 1 and 3 produce no frame_we.
